// File: rtl/ex_stage_pkg.sv
// Shared ALU operation/result-class encodings and helpers for the decode and execute stages.
// Encodings must stay in step with the decoder, which drives aluop/alusel.
package ex_stage_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 8;
  localparam int ALU_SEL_W  = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_NOP   = 8'b0000_0000,
    OP_SRL   = 8'b0000_0010,
    OP_SRA   = 8'b0000_0011,
    OP_MOVZ  = 8'b0000_1010,
    OP_MOVN  = 8'b0000_1011,
    OP_MFHI  = 8'b0001_0000,
    OP_MTHI  = 8'b0001_0001,
    OP_MFLO  = 8'b0001_0010,
    OP_MTLO  = 8'b0001_0011,
    OP_MULT  = 8'b0001_1000,
    OP_MULTU = 8'b0001_1001,
    OP_ADD   = 8'b0010_0000,
    OP_ADDU  = 8'b0010_0001,
    OP_SUB   = 8'b0010_0010,
    OP_SUBU  = 8'b0010_0011,
    OP_AND   = 8'b0010_0100,
    OP_OR    = 8'b0010_0101,
    OP_XOR   = 8'b0010_0110,
    OP_NOR   = 8'b0010_0111,
    OP_SLT   = 8'b0010_1010,
    OP_SLTU  = 8'b0010_1011,
    OP_ADDI  = 8'b0101_0101,
    OP_ADDIU = 8'b0101_0110,
    OP_SLL   = 8'b0111_1100,
    OP_MUL   = 8'b1010_1001,
    OP_CLZ   = 8'b1011_0000,
    OP_CLO   = 8'b1011_0001
  } alu_op_e;

  typedef enum logic [ALU_SEL_W-1:0] {
    SEL_NOP   = 3'b000,
    SEL_LOGIC = 3'b001,
    SEL_SHIFT = 3'b010,
    SEL_MOVE  = 3'b011,
    SEL_ARITH = 3'b100,
    SEL_MUL   = 3'b101
  } alu_sel_e;

  typedef struct packed {
    logic [REG_W-1:0] hi;
    logic [REG_W-1:0] lo;
  } hilo_t;

  typedef struct packed {
    logic  we;
    hilo_t val;
  } hilo_wr_t;

  // Leading-zero count; an all-zero word yields 32.
  function automatic logic [5:0] clz32(input logic [31:0] x);
    logic [5:0] n;
    logic       hit;
    n   = 6'd0;
    hit = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!hit) begin
        if (x[i]) hit = 1'b1;
        else      n   = n + 6'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/ex_stage_mult_iter.sv
// Iterative 32x32 multiplier retiring BITS_PER_CYCLE multiplier bits per cycle.
// Start cycle plus 32/N-1 busy cycles accumulate; DONE presents the product for one cycle.
module ex_stage_mult_iter #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  localparam int STEPS = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [63:0]        mcand_q, mcand_src;
  logic [31:0]        mplier_q, mplier_src;
  logic [63:0]        acc_q, acc_src, acc_step;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic [31:0]        mag_a, mag_b;
  logic               idle;

  assign idle  = (state_q == IDLE);
  assign mag_a = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign mag_b = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;

  // The start cycle already retires the first slice, straight from the live operands,
  // so the whole multiply spends exactly 32/N cycles stalled.
  always_comb begin
    mcand_src  = idle ? {32'd0, mag_a} : mcand_q;
    mplier_src = idle ? mag_b : mplier_q;
    acc_src    = idle ? 64'd0 : acc_q;
    acc_step   = acc_src;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier_src[k]) acc_step = acc_step + (mcand_src << k);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (cnt_q == CNT_W'(STEPS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((idle && start) || state_q == BUSY) begin
        mcand_q  <= mcand_src << BITS_PER_CYCLE;
        mplier_q <= mplier_src >> BITS_PER_CYCLE;
        acc_q    <= acc_step;
      end
      if (idle && start) begin
        cnt_q <= CNT_W'(1);
        neg_q <= is_signed & (op_a[31] ^ op_b[31]);
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign busy    = (state_q == BUSY);
  assign done    = (state_q == DONE);
  assign product = neg_q ? (~acc_q + 64'd1) : acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU result mux, HI/LO forwarding, overflow squash, CLZ/CLO, iterative multiply.
// Non-multiply ops are 0-cycle; multiplies raise stallreq_o for 32/N cycles, then one result cycle.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALU_OP_W-1:0]   aluop_i,
  input  logic [ALU_SEL_W-1:0]  alusel_i,
  input  logic [REG_W-1:0]      reg1_i,
  input  logic [REG_W-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [REG_W-1:0]      hi_i,
  input  logic [REG_W-1:0]      lo_i,
  input  logic                  mem_whilo_i,
  input  logic [REG_W-1:0]      mem_hi_i,
  input  logic [REG_W-1:0]      mem_lo_i,
  input  logic                  wb_whilo_i,
  input  logic [REG_W-1:0]      wb_hi_i,
  input  logic [REG_W-1:0]      wb_lo_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic                  whilo_o,
  output logic [REG_W-1:0]      hi_o,
  output logic [REG_W-1:0]      lo_o,
  output logic                  stallreq_o
);

  alu_op_e     op;
  alu_sel_e    sel;
  hilo_t       eff;
  hilo_wr_t    hw;
  logic [32:0] sum33;
  logic        ov;
  logic        is_mul;
  logic        mul_busy, mul_done;
  logic [63:0] mul_product;
  logic [31:0] wdata_c;
  logic        wreg_c;

  assign op  = alu_op_e'(aluop_i);
  assign sel = alu_sel_e'(alusel_i);

  // Younger HI/LO writes shadow older ones.
  always_comb begin
    if (mem_whilo_i)     eff = '{hi: mem_hi_i, lo: mem_lo_i};
    else if (wb_whilo_i) eff = '{hi: wb_hi_i,  lo: wb_lo_i};
    else                 eff = '{hi: hi_i,     lo: lo_i};
  end

  // One sign bit of headroom makes signed overflow a simple top-two-bits mismatch.
  assign sum33 = (op == OP_SUB || op == OP_SUBU) ? ({reg1_i[31], reg1_i} - {reg2_i[31], reg2_i})
                                                 : ({reg1_i[31], reg1_i} + {reg2_i[31], reg2_i});
  assign ov    = sum33[32] ^ sum33[31];

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL);

  ex_stage_mult_iter #(
    .BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .start     (is_mul),
    .is_signed (op != OP_MULTU),
    .op_a      (reg1_i),
    .op_b      (reg2_i),
    .busy      (mul_busy),
    .done      (mul_done),
    .product   (mul_product)
  );

  always_comb begin
    wdata_c = '0;
    wreg_c  = wreg_i;
    hw      = '0;
    case (sel)
      SEL_LOGIC: begin
        case (op)
          OP_OR:   wdata_c = reg1_i | reg2_i;
          OP_AND:  wdata_c = reg1_i & reg2_i;
          OP_XOR:  wdata_c = reg1_i ^ reg2_i;
          OP_NOR:  wdata_c = ~(reg1_i | reg2_i);
          default: wdata_c = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (op)
          OP_SLL:  wdata_c = reg2_i << reg1_i[4:0];
          OP_SRL:  wdata_c = reg2_i >> reg1_i[4:0];
          OP_SRA:  wdata_c = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
          default: wdata_c = '0;
        endcase
      end
      SEL_MOVE: begin
        case (op)
          OP_MFHI:          wdata_c = eff.hi;
          OP_MFLO:          wdata_c = eff.lo;
          OP_MOVN, OP_MOVZ: wdata_c = reg1_i;
          default:          wdata_c = '0;
        endcase
      end
      SEL_ARITH: begin
        case (op)
          OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU, OP_SUB, OP_SUBU: wdata_c = sum33[31:0];
          OP_SLT:  wdata_c = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
          OP_SLTU: wdata_c = {31'd0, reg1_i < reg2_i};
          OP_CLZ:  wdata_c = {26'd0, clz32(reg1_i)};
          OP_CLO:  wdata_c = {26'd0, clz32(~reg1_i)};
          default: wdata_c = '0;
        endcase
      end
      SEL_MUL: begin
        if (op == OP_MUL && mul_done) wdata_c = mul_product[31:0];
      end
      default: wdata_c = '0;
    endcase

    case (op)
      OP_ADD, OP_ADDI, OP_SUB: if (ov) wreg_c = 1'b0;
      OP_MULT, OP_MULTU: begin
        wreg_c = 1'b0;
        if (mul_done) hw = '{we: 1'b1, val: '{hi: mul_product[63:32], lo: mul_product[31:0]}};
      end
      OP_MTHI: hw = '{we: 1'b1, val: '{hi: reg1_i, lo: eff.lo}};
      OP_MTLO: hw = '{we: 1'b1, val: '{hi: eff.hi, lo: reg1_i}};
      default: ;
    endcase
  end

  assign wd_o       = rst ? '0   : wd_i;
  assign wreg_o     = rst ? 1'b0 : wreg_c;
  assign wdata_o    = rst ? '0   : wdata_c;
  assign whilo_o    = rst ? 1'b0 : hw.we;
  assign hi_o       = rst ? '0   : hw.val.hi;
  assign lo_o       = rst ? '0   : hw.val.lo;
  assign stallreq_o = ~rst & ((is_mul & ~mul_done) | mul_busy);

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage (N=1): ALU vectors, HI/LO forwarding, multiplies, reset mid-multiply.
// Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop_i = '0;
  logic [2:0]  alusel_i = '0;
  logic [31:0] reg1_i = '0, reg2_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [31:0] hi_i = '0, lo_i = '0;
  logic        mem_whilo_i = 1'b0, wb_whilo_i = 1'b0;
  logic [31:0] mem_hi_i = '0, mem_lo_i = '0, wb_hi_i = '0, wb_lo_i = '0;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage #(.MUL_BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .hi_i(hi_i), .lo_i(lo_i),
    .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
    .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b);
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b;
    wd_i = 5'd5; wreg_i = 1'b1;
    mem_whilo_i = 1'b0; wb_whilo_i = 1'b0;
  endtask

  // Drives a multiply and follows it to the first non-stalled cycle (its result cycle).
  task automatic mul_run(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b, output int stalls);
    drive(op, sel, a, b);
    #4;
    stalls = 0;
    while (stallreq_o === 1'b1 && stalls < 100) begin
      stalls++;
      @(posedge clk); #5;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(OP_MULT, SEL_NOP, 32'h3, 32'h5);
    repeat (2) @(posedge clk);
    #4;
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stallreq_o); end
    total++; if (wd_o !== 5'd0) begin bad++; $display("FAIL rst_wd: got %0d want 0", wd_o); end
    total++; if (wreg_o !== 1'b0) begin bad++; $display("FAIL rst_wreg: got %b want 0", wreg_o); end
    total++; if (whilo_o !== 1'b0) begin bad++; $display("FAIL rst_whilo: got %b want 0", whilo_o); end
    total++; if (wdata_o !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h want 0", wdata_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(OP_NOP, SEL_NOP, 32'h0, 32'h0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_wreg;
    logic        chk_data;
  } vec_t;

  task automatic test_alu;
    vec_t v[22];
    v[0]  = '{OP_OR,    SEL_LOGIC, 32'h0F0F0000, 32'h0000FFFF, 32'h0F0FFFFF, 1'b1, 1'b1};
    v[1]  = '{OP_AND,   SEL_LOGIC, 32'h0F0F0000, 32'h00FF00FF, 32'h000F0000, 1'b1, 1'b1};
    v[2]  = '{OP_XOR,   SEL_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b1, 1'b1};
    v[3]  = '{OP_NOR,   SEL_LOGIC, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1};
    v[4]  = '{OP_SLL,   SEL_SHIFT, 32'h00000004, 32'h0000000F, 32'h000000F0, 1'b1, 1'b1};
    v[5]  = '{OP_SRL,   SEL_SHIFT, 32'h00000004, 32'h80000000, 32'h08000000, 1'b1, 1'b1};
    v[6]  = '{OP_SRA,   SEL_SHIFT, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b1, 1'b1};
    v[7]  = '{OP_ADD,   SEL_ARITH, 32'h7FFFFFFF, 32'h00000001, 32'h0,        1'b0, 1'b0};
    v[8]  = '{OP_ADDU,  SEL_ARITH, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b1};
    v[9]  = '{OP_SUB,   SEL_ARITH, 32'h00000000, 32'h80000000, 32'h0,        1'b0, 1'b0};
    v[10] = '{OP_SUBU,  SEL_ARITH, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b1};
    v[11] = '{OP_ADDI,  SEL_ARITH, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0};
    v[12] = '{OP_ADDIU, SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1};
    v[13] = '{OP_SLT,   SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b1};
    v[14] = '{OP_SLTU,  SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1};
    v[15] = '{OP_CLZ,   SEL_ARITH, 32'h00000000, 32'h0,        32'd32,       1'b1, 1'b1};
    v[16] = '{OP_CLZ,   SEL_ARITH, 32'h00010000, 32'h0,        32'd15,       1'b1, 1'b1};
    v[17] = '{OP_CLO,   SEL_ARITH, 32'hFFFFFFFF, 32'h0,        32'd32,       1'b1, 1'b1};
    v[18] = '{OP_CLO,   SEL_ARITH, 32'hF0000000, 32'h0,        32'd4,        1'b1, 1'b1};
    v[19] = '{OP_MOVN,  SEL_MOVE,  32'h12345678, 32'h1,        32'h12345678, 1'b1, 1'b1};
    v[20] = '{8'hFF,    SEL_LOGIC, 32'hAAAA5555, 32'h5555AAAA, 32'h00000000, 1'b1, 1'b1};
    v[21] = '{OP_SUB,   SEL_ARITH, 32'h00000005, 32'h00000003, 32'h00000002, 1'b1, 1'b1};
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      drive(v[i].op, v[i].sel, v[i].a, v[i].b);
      #4;
      total++;
      if (wreg_o !== v[i].exp_wreg) begin
        bad++; $display("FAIL alu%0d_wreg: got %b want %b", i, wreg_o, v[i].exp_wreg);
      end
      if (v[i].chk_data) begin
        total++;
        if (wdata_o !== v[i].exp) begin
          bad++; $display("FAIL alu%0d_wdata: got %h want %h", i, wdata_o, v[i].exp);
        end
      end
      total++;
      if (wd_o !== 5'd5 || whilo_o !== 1'b0 || stallreq_o !== 1'b0) begin
        bad++; $display("FAIL alu%0d_side: wd=%0d whilo=%b stall=%b want 5/0/0", i, wd_o, whilo_o, stallreq_o);
      end
    end
  endtask

  task automatic test_hilo;
    hi_i = 32'hCCCC0000; lo_i = 32'hCCCC1111;
    @(posedge clk); #1;
    drive(OP_MFHI, SEL_MOVE, 32'h0, 32'h0);
    mem_whilo_i = 1'b1; mem_hi_i = 32'hAAAA0000; mem_lo_i = 32'hAAAA1111;
    wb_whilo_i  = 1'b1; wb_hi_i  = 32'hBBBB0000; wb_lo_i  = 32'hBBBB1111;
    #4;
    total++; if (wdata_o !== 32'hAAAA0000) begin bad++; $display("FAIL mfhi_mem: got %h want aaaa0000", wdata_o); end
    @(posedge clk); #1;
    drive(OP_MFLO, SEL_MOVE, 32'h0, 32'h0);
    wb_whilo_i = 1'b1;
    #4;
    total++; if (wdata_o !== 32'hBBBB1111) begin bad++; $display("FAIL mflo_wb: got %h want bbbb1111", wdata_o); end
    @(posedge clk); #1;
    drive(OP_MFHI, SEL_MOVE, 32'h0, 32'h0);
    #4;
    total++; if (wdata_o !== 32'hCCCC0000) begin bad++; $display("FAIL mfhi_arch: got %h want cccc0000", wdata_o); end
    @(posedge clk); #1;
    drive(OP_MTHI, SEL_NOP, 32'h11112222, 32'h0);
    mem_whilo_i = 1'b1;
    #4;
    total++;
    if (whilo_o !== 1'b1 || hi_o !== 32'h11112222 || lo_o !== 32'hAAAA1111) begin
      bad++; $display("FAIL mthi: whilo=%b hi=%h lo=%h want 1/11112222/aaaa1111", whilo_o, hi_o, lo_o);
    end
    @(posedge clk); #1;
    drive(OP_MTLO, SEL_NOP, 32'h33334444, 32'h0);
    wb_whilo_i = 1'b1;
    #4;
    total++;
    if (whilo_o !== 1'b1 || hi_o !== 32'hBBBB0000 || lo_o !== 32'h33334444) begin
      bad++; $display("FAIL mtlo: whilo=%b hi=%h lo=%h want 1/bbbb0000/33334444", whilo_o, hi_o, lo_o);
    end
  endtask

  task automatic test_mult;
    int stalls;
    @(posedge clk); #1;
    mul_run(OP_MULT, SEL_NOP, 32'hFFFFFFFD, 32'h5, stalls);
    total++; if (stalls !== 32) begin bad++; $display("FAIL mult_stalls: got %0d want 32", stalls); end
    total++;
    if (whilo_o !== 1'b1 || hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFF1 || wreg_o !== 1'b0) begin
      bad++; $display("FAIL mult_neg: whilo=%b hi=%h lo=%h wreg=%b want 1/ffffffff/fffffff1/0", whilo_o, hi_o, lo_o, wreg_o);
    end
    @(posedge clk); #1;
    mul_run(OP_MULTU, SEL_NOP, 32'hFFFFFFFF, 32'h2, stalls);
    total++; if (stalls !== 32) begin bad++; $display("FAIL multu_stalls: got %0d want 32", stalls); end
    total++;
    if (whilo_o !== 1'b1 || hi_o !== 32'h00000001 || lo_o !== 32'hFFFFFFFE) begin
      bad++; $display("FAIL multu: whilo=%b hi=%h lo=%h want 1/00000001/fffffffe", whilo_o, hi_o, lo_o);
    end
    @(posedge clk); #1;
    mul_run(OP_MUL, SEL_MUL, 32'h7, 32'h6, stalls);
    total++; if (stalls !== 32) begin bad++; $display("FAIL mul_stalls: got %0d want 32", stalls); end
    total++;
    if (wdata_o !== 32'd42 || whilo_o !== 1'b0 || wreg_o !== 1'b1) begin
      bad++; $display("FAIL mul: wdata=%h whilo=%b wreg=%b want 0000002a/0/1", wdata_o, whilo_o, wreg_o);
    end
  endtask

  task automatic test_back_to_back;
    int stalls;
    @(posedge clk); #1;
    mul_run(OP_MULT, SEL_NOP, 32'h2, 32'h3, stalls);
    total++;
    if (stalls !== 32 || hi_o !== 32'h0 || lo_o !== 32'h6) begin
      bad++; $display("FAIL b2b_first: stalls=%0d hi=%h lo=%h want 32/0/6", stalls, hi_o, lo_o);
    end
    @(posedge clk); #1;
    mul_run(OP_MULT, SEL_NOP, 32'h80000000, 32'h80000000, stalls);
    total++;
    if (stalls !== 32 || whilo_o !== 1'b1 || hi_o !== 32'h40000000 || lo_o !== 32'h0) begin
      bad++; $display("FAIL b2b_second: stalls=%0d whilo=%b hi=%h lo=%h want 32/1/40000000/0", stalls, whilo_o, hi_o, lo_o);
    end
  endtask

  task automatic test_reset_mid_mult;
    int stalls;
    @(posedge clk); #1;
    drive(OP_MULT, SEL_NOP, 32'h7, 32'h9);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #4;
    total++;
    if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid_in: stall=%b whilo=%b want 0/0", stallreq_o, whilo_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(OP_NOP, SEL_NOP, 32'h0, 32'h0);
    #4;
    total++;
    if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid_after: stall=%b whilo=%b want 0/0", stallreq_o, whilo_o);
    end
    @(posedge clk); #1;
    mul_run(OP_MULT, SEL_NOP, 32'h3, 32'h4, stalls);
    total++;
    if (stalls !== 32 || whilo_o !== 1'b1 || hi_o !== 32'h0 || lo_o !== 32'd12) begin
      bad++; $display("FAIL rst_restart: stalls=%0d whilo=%b hi=%h lo=%h want 32/1/0/0000000c", stalls, whilo_o, hi_o, lo_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_hilo();
    test_mult();
    test_back_to_back();
    test_reset_mid_mult();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
